// File: rtl/pid_wb_master_if.sv
// Wishbone classic bus between the PID sequencer (master) and the PID slave.
interface pid_wb_master_if #(
    parameter int unsigned ADR_NB = 16
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADR_NB-1:0] adr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output cyc, stb, we, adr, wdata, input ack, rdata);
    modport slave  (input cyc, stb, we, adr, wdata, output ack, rdata);
endinterface

// File: rtl/pid_wb_master.sv
// Wishbone classic master sequencing PID configuration, clear and per-sample
// pv write / un read / of read, with a bounded ack wait on every strobe.
module pid_wb_master #(
    parameter int unsigned       ADR_NB      = 16,
    parameter logic [ADR_NB-1:0] BASE_ADR    = '0,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    pid_wb_master_if.master wb,
    input  logic            i_cfg_load,
    input  logic [15:0]     i_kp,
    input  logic [15:0]     i_ki,
    input  logic [15:0]     i_kd,
    input  logic [15:0]     i_sp,
    input  logic            i_clr,
    input  logic            i_pv_valid,
    input  logic [15:0]     i_pv,
    output logic            o_pv_ready,
    output logic [31:0]     o_un,
    output logic [4:0]      o_of,
    output logic            o_un_valid,
    output logic            o_busy,
    output logic            o_timeout
);
    typedef enum logic [3:0] {
        IDLE, CFG_KP, CFG_KI, CFG_KD, CFG_SP, CLR, S_PV, S_UN, S_OF, GAP
    } state_e;

    state_e      state_q, nxt_q, acc_st, tgt;
    logic        cyc_q, we_q;
    logic [ADR_NB-1:0] adr_q, t_adr;
    logic [31:0] dat_q, t_dat, un_tmp_q, un_q;
    logic [15:0] cnt_q, ki_q, kd_q, sp_q;
    logic [4:0]  of_q;
    logic        un_valid_q, tmo_q, cfg_pend_q, clr_pend_q;
    logic        cfg_req, clr_req, idle, start, t_we;
    logic [7:0]  t_off;

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic state_e succ(input state_e s);
        case (s)
            CFG_KP:  return CFG_KI;
            CFG_KI:  return CFG_KD;
            CFG_KD:  return CFG_SP;
            S_PV:    return S_UN;
            S_UN:    return S_OF;
            default: return IDLE;
        endcase
    endfunction

    always_comb begin
        idle    = (state_q == IDLE);
        cfg_req = i_cfg_load | cfg_pend_q;
        clr_req = i_clr | clr_pend_q;
        acc_st  = IDLE;
        if (cfg_req)         acc_st = CFG_KP;
        else if (clr_req)    acc_st = CLR;
        else if (i_pv_valid) acc_st = S_PV;
        tgt   = idle ? acc_st : nxt_q;
        start = (idle && acc_st != IDLE) || (state_q == GAP && nxt_q != IDLE);
        // Bus setup for the strobe about to start; kp and pv only ever launch from IDLE
        t_we  = 1'b1;
        t_off = 8'h00;
        t_dat = 32'h0;
        case (tgt)
            CFG_KP: begin t_off = 8'h00; t_dat = sext(i_kp); end
            CFG_KI: begin t_off = 8'h04; t_dat = sext(ki_q); end
            CFG_KD: begin t_off = 8'h08; t_dat = sext(kd_q); end
            CFG_SP: begin t_off = 8'h0C; t_dat = sext(sp_q); end
            S_PV:   begin t_off = 8'h10; t_dat = sext(i_pv); end
            S_UN:   begin t_off = 8'h20; t_we = 1'b0; end
            S_OF:   begin t_off = 8'h28; t_we = 1'b0; end
            CLR:    begin t_off = 8'h2C; end
            default: ;
        endcase
        t_adr = BASE_ADR + ADR_NB'(t_off);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            nxt_q      <= IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            cnt_q      <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            sp_q       <= '0;
            un_tmp_q   <= '0;
            un_q       <= '0;
            of_q       <= '0;
            un_valid_q <= 1'b0;
            tmo_q      <= 1'b0;
            cfg_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            un_valid_q <= 1'b0;
            // Pulses seen while busy wait one-deep; a clr losing to cfg in IDLE also waits
            if (!idle) begin
                if (i_cfg_load) cfg_pend_q <= 1'b1;
                if (i_clr)      clr_pend_q <= 1'b1;
            end else if (cfg_req) begin
                cfg_pend_q <= 1'b0;
                clr_pend_q <= clr_req;
                ki_q       <= i_ki;
                kd_q       <= i_kd;
                sp_q       <= i_sp;
            end else if (clr_req) begin
                clr_pend_q <= 1'b0;
            end

            if (start) begin
                state_q <= tgt;
                cyc_q   <= 1'b1;
                we_q    <= t_we;
                adr_q   <= t_adr;
                dat_q   <= t_dat;
                cnt_q   <= '0;
            end else if (state_q == GAP) begin
                state_q <= IDLE;
            end else if (cyc_q) begin
                if (wb.ack) begin
                    cyc_q   <= 1'b0;
                    state_q <= GAP;
                    nxt_q   <= succ(state_q);
                    if (state_q == S_UN) un_tmp_q <= wb.rdata;
                    if (state_q == S_OF) begin
                        un_q       <= un_tmp_q;
                        of_q       <= wb.rdata[4:0];
                        un_valid_q <= 1'b1;
                    end
                    if (state_q == CLR) tmo_q <= 1'b0;
                end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                    cyc_q   <= 1'b0;
                    state_q <= GAP;
                    nxt_q   <= IDLE;
                    tmo_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    assign wb.cyc     = cyc_q;
    assign wb.stb     = cyc_q;
    assign wb.we      = we_q;
    assign wb.adr     = adr_q;
    assign wb.wdata   = dat_q;
    assign o_pv_ready = !i_rst && idle && !cfg_req && !clr_req;
    assign o_un       = un_q;
    assign o_of       = of_q;
    assign o_un_valid = un_valid_q;
    assign o_busy     = (state_q != IDLE);
    assign o_timeout  = tmo_q;
endmodule

// File: tb/tb_pid_wb_master.sv
// Directed bench for pid_wb_master: behavioural PID slave with stall/no-ack
// controls, a bus transaction log and table-driven expected transactions.
module tb_pid_wb_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pid_wb_master_if #(.ADR_NB(16)) wb();

    logic        cfg_load, clr, pv_valid, pv_ready, un_valid, busy, tmo;
    logic [15:0] kp, ki, kd, sp, pv;
    logic [31:0] un;
    logic [4:0]  of;

    pid_wb_master #(.ADR_NB(16), .BASE_ADR(16'h0000), .TIMEOUT_CYC(16)) dut (
        .i_clk(clk), .i_rst(rst), .wb(wb),
        .i_cfg_load(cfg_load), .i_kp(kp), .i_ki(ki), .i_kd(kd), .i_sp(sp),
        .i_clr(clr), .i_pv_valid(pv_valid), .i_pv(pv), .o_pv_ready(pv_ready),
        .o_un(un), .o_of(of), .o_un_valid(un_valid), .o_busy(busy), .o_timeout(tmo)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
    } txn_t;

    typedef struct {
        logic [15:0] pv;
        int          stall;
        logic [31:0] wdat;
    } smp_t;

    // Slave: acks after an optional stall on un, holds ack until stb falls
    int stall_un = 0;
    bit no_ack_un = 1'b0;
    int wcnt = 0;
    always @(posedge clk) begin
        if (rst || !(wb.cyc && wb.stb)) begin
            wb.ack <= 1'b0;
            wcnt   <= 0;
        end else if (!wb.ack) begin
            if (wb.adr == 16'h0020 && (no_ack_un || wcnt < stall_un)) begin
                wcnt <= wcnt + 1;
            end else begin
                wb.ack   <= 1'b1;
                wb.rdata <= (wb.adr == 16'h0020) ? 32'h0000_005A :
                            (wb.adr == 16'h0028) ? 32'h0000_0001 : 32'h0;
            end
        end
    end

    txn_t        log_q[$];
    int          un_wait = 0, unv_cnt = 0, gap_viol = 0, gap_seen = 0;
    logic [31:0] unv_un = '0;
    logic [4:0]  unv_of = '0;
    logic        prev_done = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            if (wb.stb && wb.ack) log_q.push_back({wb.we, wb.adr, wb.we ? wb.wdata : wb.rdata});
            if (wb.stb && !wb.ack && wb.adr == 16'h0020) un_wait <= un_wait + 1;
            if (un_valid) begin
                unv_cnt <= unv_cnt + 1;
                unv_un  <= un;
                unv_of  <= of;
            end
            if (prev_done) begin
                gap_seen <= gap_seen + 1;
                if (wb.stb) gap_viol <= gap_viol + 1;
            end
            prev_done <= wb.stb && wb.ack;
        end else begin
            prev_done <= 1'b0;
        end
    end

    int checks = 0, fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_txn(input string nm, input int idx, input txn_t e);
        if (idx >= log_q.size()) begin
            checks++;
            fails++;
            $display("FAIL %s: missing transaction %0d, expected %0h", nm, idx, e);
        end else begin
            chk(nm, 64'(log_q[idx]), 64'(e));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        int z = 0;
        while (z < 2 && n < 2000) begin
            @(negedge clk);
            n++;
            z = busy ? 0 : z + 1;
        end
        if (n >= 2000) begin
            checks++;
            fails++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic offer_pv(input logic [15:0] v);
        pv = v;
        pv_valid = 1'b1;
        #1 chk("pv_ready_offer", 64'(pv_ready), 64'd1);
        @(negedge clk);
        pv_valid = 1'b0;
    endtask

    txn_t cfg_exp[4];
    txn_t prio_exp[5];
    smp_t smp[3];
    int   base, u0, w0, n;

    initial begin
        cfg_exp  = '{'{1'b1, 16'h00, 32'h0000_0002}, '{1'b1, 16'h04, 32'h0000_0001},
                     '{1'b1, 16'h08, 32'hFFFF_FFFF}, '{1'b1, 16'h0C, 32'h0000_0064}};
        prio_exp = '{'{1'b1, 16'h00, 32'hFFFF_8000}, '{1'b1, 16'h04, 32'h0000_7FFF},
                     '{1'b1, 16'h08, 32'h0000_0000}, '{1'b1, 16'h0C, 32'h0000_1234},
                     '{1'b1, 16'h2C, 32'h0000_0000}};
        smp      = '{'{16'h0050, 9, 32'h0000_0050}, '{16'hFFF0, 0, 32'hFFFF_FFF0},
                     '{16'h8000, 3, 32'hFFFF_8000}};
        cfg_load = 0; clr = 0; pv_valid = 0;
        kp = 0; ki = 0; kd = 0; sp = 0; pv = 0;

        repeat (3) @(negedge clk);
        chk("rst_cyc", 64'(wb.cyc), 0);
        chk("rst_stb", 64'(wb.stb), 0);
        chk("rst_adr_dat", {wb.we, wb.adr, wb.wdata}, 0);
        chk("rst_outs", {pv_ready, un_valid, busy, tmo, of, un}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_pv_ready", 64'(pv_ready), 64'd1);

        // Configuration
        base = log_q.size();
        kp = 16'h0002; ki = 16'h0001; kd = 16'hFFFF; sp = 16'h0064;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        kp = 0; ki = 0; kd = 0; sp = 0;
        wait_idle();
        chk("cfg_count", 64'(log_q.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) chk_txn("cfg_txn", base + i, cfg_exp[i]);
        chk("cfg_busy", 64'(busy), 0);

        // Samples, including a 9-cycle un stall
        for (int i = 0; i < 3; i++) begin
            base = log_q.size();
            u0 = unv_cnt;
            stall_un = smp[i].stall;
            offer_pv(smp[i].pv);
            wait_idle();
            chk("smp_count", 64'(log_q.size() - base), 64'd3);
            chk_txn("smp_pv_wr", base, '{1'b1, 16'h10, smp[i].wdat});
            chk_txn("smp_un_rd", base + 1, '{1'b0, 16'h20, 32'h5A});
            chk_txn("smp_of_rd", base + 2, '{1'b0, 16'h28, 32'h1});
            chk("smp_unv_pulses", 64'(unv_cnt - u0), 64'd1);
            chk("smp_un_of", {unv_un, 3'b0, unv_of}, {32'h5A, 3'b0, 5'h01});
        end
        stall_un = 0;

        // Priority: cfg beats clr beats pv
        base = log_q.size();
        kp = 16'h8000; ki = 16'h7FFF; kd = 16'h0000; sp = 16'h1234; pv = 16'h0011;
        cfg_load = 1'b1; clr = 1'b1; pv_valid = 1'b1;
        #1 chk("prio_pv_ready", 64'(pv_ready), 0);
        @(negedge clk);
        cfg_load = 1'b0; clr = 1'b0; pv_valid = 1'b0;
        wait_idle();
        chk("prio_count", 64'(log_q.size() - base), 64'd5);
        for (int i = 0; i < 5; i++) chk_txn("prio_txn", base + i, prio_exp[i]);
        base = log_q.size();
        offer_pv(16'h0011);
        wait_idle();
        chk_txn("prio_pv_wr", base, '{1'b1, 16'h10, 32'h11});
        chk("prio_smp_count", 64'(log_q.size() - base), 64'd3);

        // Timeout on un read, then clear
        base = log_q.size();
        u0 = unv_cnt;
        w0 = un_wait;
        no_ack_un = 1'b1;
        offer_pv(16'h0022);
        wait_idle();
        chk("tmo_wait_cycles", 64'(un_wait - w0), 64'd16);
        chk("tmo_flag", 64'(tmo), 64'd1);
        chk("tmo_no_unv", 64'(unv_cnt - u0), 0);
        chk("tmo_count", 64'(log_q.size() - base), 64'd1);
        no_ack_un = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_idle();
        chk_txn("tmo_rs_wr", base + 1, '{1'b1, 16'h2C, 32'h0});
        chk("tmo_cleared", 64'(tmo), 0);

        // Reset in the middle of a stalled un read
        stall_un = 40;
        offer_pv(16'h0033);
        n = 0;
        while (!(wb.stb && wb.adr == 16'h0020) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reached_un", 64'(n < 100), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_bus", {wb.cyc, wb.stb, wb.we}, 0);
        chk("rstmid_outs", {pv_ready, un_valid, busy, tmo, of, un}, 0);
        @(negedge clk);
        rst = 1'b0;
        stall_un = 0;
        @(negedge clk);
        base = log_q.size();
        u0 = unv_cnt;
        offer_pv(16'h0044);
        wait_idle();
        chk_txn("rstmid_pv_wr", base, '{1'b1, 16'h10, 32'h44});
        chk("rstmid_count", 64'(log_q.size() - base), 64'd3);
        chk("rstmid_unv", 64'(unv_cnt - u0), 64'd1);

        chk("gap_violations", 64'(gap_viol), 0);
        chk("gap_seen", 64'(gap_seen > 20), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
